adder_arbiter: RTL
==================

# adder_arbiter

Round-robin arbiter and result sequencer that shares one 2-bit `Adder` datapath (3-bit sum) among `NREQ` requesters. Each requester offers one 2-bit + 2-bit add per transaction over a valid/ready handshake. The block grants one request per cycle, latches the `Adder` result tagged with the requester ID into a single-entry output register, and drains that register over a downstream valid/ready handshake. It sits between the scalar clients of the arithmetic unit and the shared `Adder` instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `IDW`, default 2: requester ID width, equal to clog2(`NREQ`).
- `clock`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high.
- `req_valid`  input  `NREQ`: bit i means requester i offers an operand pair.
- `req_ready`  output  `NREQ`: one-hot or zero; bit i means requester i is granted this cycle.
- `req_a`  input  2*`NREQ`: operand a; requester i uses bits [2i+1:2i].
- `req_b`  input  2*`NREQ`: operand b; same packing as `req_a`.
- `rsp_valid`  output  1: output register holds a result.
- `rsp_ready`  input  1: downstream accepts the result.
- `rsp_id`  output  `IDW`: requester index of the held result.
- `rsp_sum`  output  3: zero-extended a+b, carry in bit 2.

## Operation
- State:
  - round-robin pointer `ptr` (`IDW` bits, range 0..`NREQ`-1);
  - output register {`full`, `id`, `sum`}.
  - Two-state FSM: EMPTY (`full`=0), FULL (`full`=1).
- `can_accept` = EMPTY, or (FULL and `rsp_ready`).
- Grant rule: `g` is the first index i with `req_valid[i]`=1, searching `ptr`, `ptr`+1, …, `NREQ`-1, 0, …, `ptr`-1.
- `req_ready[g]`=1 only when `can_accept`=1. All other bits of `req_ready` are 0.
- `req_ready` is combinational from `req_valid`, `ptr`, `full` and `rsp_ready`. It never depends on `req_a` or `req_b`.
- Transfer on requester g (`req_valid[g]` & `req_ready[g]`):
  - the `Adder` is driven with `req_a[g]` and `req_b[g]`;
  - `sum` <= `Adder` out and `id` <= g;
  - `full` <= 1;
  - `ptr` <= (g+1) mod `NREQ`.
- With no transfer, `ptr` holds.
- FULL with `rsp_ready`=1 and no new transfer: `full` <= 0. `id` and `sum` hold their stale values.
- FULL with `rsp_ready`=1 and a new transfer in the same cycle: the register reloads and stays FULL (no bubble).
- FULL with `rsp_ready`=0: `full`, `id` and `sum` are all held. `rsp_valid` stays 1 until accepted.
- Mux input when no grant: the `Adder` inputs are driven to 0.
- Arithmetic: `rsp_sum` = a + b, range 0..6. There is no carry-in and no overflow; 3+3 gives 3'b110.
- Reset:
  - `ptr`=0, `full`=0, `id`=0, `sum`=0;
  - so `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0 and `req_ready`=0 during and after reset.
  - Reset asserted mid-transaction discards any held result. No grant is issued in a cycle with `reset`=1.
- A requester must hold `req_valid` and its operands stable until it is granted. The block does not check this.

## Timing
- Latency: request accepted in cycle N gives `rsp_valid`=1 with its result in cycle N+1.
- Throughput: one result per cycle while `rsp_ready`=1 is held.
- Fairness: a continuously valid requester is granted within `NREQ` transfers.
- Combinational paths:
  - `rsp_ready` -> `req_ready` (allowed);
  - `req_valid` -> `req_ready` (allowed);
  - `req_a`/`req_b` -> `Adder` -> register only. There is no combinational path from the operands to any output.
- `rsp_id` and `rsp_sum` are driven only from registers.

## Structure
- Package `adder_arb_pkg`:
  - `NREQ_DEF`, `SUM_W`=3, `OPND_W`=2;
  - FSM enum {EMPTY, FULL};
  - `rsp_t` struct {id, sum}.
- Sub-module: one instance of the team's existing `Adder` (ports `a`, `b`, `out`). It is not modified.
- Round-robin priority search is a function inside the block, not a separate module.

## Test plan
- Single requester: `NREQ`=4, requester 2 sends a=3, b=2 with `rsp_ready`=1 -> next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=5; `ptr` becomes 3.
- All four requesters valid for 8 cycles, `rsp_ready`=1, operands a=i, b=1 -> grant order 0,1,2,3,0,1,2,3; sums 1,2,3,4 repeating; a response every cycle.
- Backpressure: requester 1 sends 3+3, `rsp_ready`=0 for 3 cycles -> `rsp_valid`=1 with `rsp_sum`=6, `rsp_id`=1 held; `req_ready`=0 for all requesters; after `rsp_ready` rises, requester 3 (pending) is granted in that same cycle.
- Drain without refill: a result is held, `rsp_ready`=1, no requests -> `rsp_valid`=0 next cycle and `ptr` unchanged.
- Reset mid-operation: a result is held and requesters 0 and 2 are valid; `reset`=1 for one cycle -> `rsp_valid`=0, `req_ready`=0 during reset; first grant afterwards goes to requester 0 (`ptr`=0).
- Exhaustive arithmetic: all 16 (a,b) pairs through requester 0 -> `rsp_sum` equals a+b for every pair.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// adder_arb_pkg: shared types and constants for the adder_arbiter slice.
//   NREQ_DEF : default requester count
//   OPND_W   : operand width fed to the shared Adder
//   SUM_W    : Adder result width (carry lands in the top bit)
//   ID_MAXW  : widest requester ID the block supports (NREQ up to 16)
//   state_t  : output-register FSM {EMPTY, FULL}
//   rsp_t    : held response {id, sum}
package adder_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int OPND_W   = 2;
    localparam int SUM_W    = 3;
    localparam int ID_MAXW  = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // id is sized for the largest legal NREQ; the top uses the low IDW bits.
    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic [SUM_W-1:0]   sum;
    } rsp_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Adder: the shared 2-bit + 2-bit datapath.
//   a, b : operands
//   out  : zero-extended sum, carry in bit 2
module Adder
    import adder_arb_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [SUM_W-1:0]  out
);

    assign out = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one Adder among NREQ requesters,
// with a single-entry output register drained over valid/ready.
//   clock, reset        : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [2i+1:2i]
//   rsp_valid/rsp_ready : downstream handshake
//   rsp_id, rsp_sum     : registered requester index and sum
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OPND_W*NREQ-1:0]   req_a,
    input  logic [OPND_W*NREQ-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [SUM_W-1:0]         rsp_sum
);

    state_t                       state, state_nxt;
    rsp_t                         rsp_q;
    logic [IDW-1:0]               ptr;
    logic [IDW-1:0]               gnt_idx;
    logic                         gnt_hit;
    logic                         can_accept;
    logic                         grant;
    logic [NREQ-1:0][OPND_W-1:0]  a_v, b_v;
    logic [OPND_W-1:0]            add_a, add_b;
    logic [SUM_W-1:0]             add_out;
    logic                         unused_id_hi;

    // First valid index scanning ptr, ptr+1, ..., wrapping to ptr-1.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  p,
                                               output logic           hit);
        logic [IDW-1:0] ii;
        rr_pick = '0;
        hit     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            ii = IDW'((int'(p) + k) % NREQ);
            if (!hit && v[ii]) begin
                hit     = 1'b1;
                rr_pick = ii;
            end
        end
    endfunction

    assign a_v = req_a;
    assign b_v = req_b;

    always_comb begin
        gnt_idx = rr_pick(req_valid, ptr, gnt_hit);
    end

    assign can_accept = (state == EMPTY) || rsp_ready;
    // Reset blocks grants so nothing is consumed from a requester that cycle.
    assign grant      = gnt_hit && can_accept && !reset;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    // Idle Adder inputs are zeroed so operands only reach it when granted.
    assign add_a = grant ? a_v[gnt_idx] : '0;
    assign add_b = grant ? b_v[gnt_idx] : '0;

    Adder u_add (
        .a   (add_a),
        .b   (add_b),
        .out (add_out)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (grant) state_nxt = FULL;
            FULL:  if (!grant && rsp_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // id/sum only change on a grant; a plain drain leaves them stale.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_q <= '0;
            ptr   <= '0;
        end else if (grant) begin
            rsp_q <= '{id: ID_MAXW'(gnt_idx), sum: add_out};
            ptr   <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign rsp_valid    = (state == FULL);
    assign rsp_id       = rsp_q.id[IDW-1:0];
    assign rsp_sum      = rsp_q.sum;
    assign unused_id_hi = ^rsp_q.id;

endmodule
